// File: rtl/nlz_norm_pipe_if.sv
// Operand/result handshake bundle for nlz_norm_pipe: valid/ready on both sides
// plus the operand, mode, tag, flush and the normalised result fields.
interface nlz_norm_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic                 I_Valid;
  logic                 O_Ready;
  logic [WIDTH-1:0]     I_Data;
  logic                 I_Mode;
  logic [TAG_WIDTH-1:0] I_Tag;
  logic                 I_Flush;
  logic                 O_Valid;
  logic                 I_Ready;
  logic [CW-1:0]        O_Num;
  logic [WIDTH-1:0]     O_Data;
  logic                 O_Zero;
  logic [TAG_WIDTH-1:0] O_Tag;

  modport slave (
    input  I_Valid, I_Data, I_Mode, I_Tag, I_Flush, I_Ready,
    output O_Ready, O_Valid, O_Num, O_Data, O_Zero, O_Tag
  );

  modport master (
    output I_Valid, I_Data, I_Mode, I_Tag, I_Flush, I_Ready,
    input  O_Ready, O_Valid, O_Num, O_Data, O_Zero, O_Tag
  );
endinterface

// File: rtl/nlz_norm_pipe.sv
// Two-stage leading-zero / redundant-sign-bit counter with left normaliser.
// Stage 1 counts with a leaf-and-merge tree, stage 2 shifts by the registered count.
module nlz_norm_pipe #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  nlz_norm_pipe_if.slave bus
);
  localparam int CW     = $clog2(WIDTH) + 1;
  localparam int LEAVES = WIDTH / 8;
  localparam int LVLS   = $clog2(LEAVES);

  function automatic logic [2:0] leaf_lzc(input logic [7:0] b);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 3'(7 - i);
    end
    return n;
  endfunction

  // Leaf 0 holds the MSB byte; each merge prefers the upper (more significant) half.
  function automatic logic [CW-1:0] lzc_tree(input logic [WIDTH-1:0] v);
    logic [CW-1:0] cnt [LEAVES];
    logic          hit [LEAVES];
    logic [7:0]    byte_v;
    for (int j = 0; j < LEAVES; j++) begin
      byte_v = v[WIDTH-1-8*j -: 8];
      hit[j] = |byte_v;
      cnt[j] = CW'(leaf_lzc(byte_v));
    end
    for (int k = 0; k < LVLS; k++) begin
      for (int j = 0; j < LEAVES / 2; j++) begin
        if (j < (LEAVES >> (k + 1))) begin
          if (hit[2*j]) cnt[j] = cnt[2*j];
          else          cnt[j] = cnt[2*j+1] | (CW'(1) << (3 + k));
          hit[j] = hit[2*j] | hit[2*j+1];
        end
      end
    end
    return hit[0] ? cnt[0] : CW'(WIDTH);
  endfunction

  function automatic logic [WIDTH-1:0] shl_log(input logic [WIDTH-1:0] v,
                                               input logic [CW-1:0]    s);
    logic [WIDTH-1:0] x;
    x = v;
    for (int i = 0; i < CW; i++) begin
      if (s[i]) x = x << (1 << i);
    end
    return x;
  endfunction

  logic                 vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0]     data_p1_q, data_p1_d, data_p2_q, data_p2_d;
  logic [CW-1:0]        num_p1_q, num_p1_d, num_p2_q, num_p2_d;
  logic                 zero_p1_q, zero_p1_d, zero_p2_q, zero_p2_d;
  logic [TAG_WIDTH-1:0] tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  logic                 adv_p1, adv_p2, acc_p0, load_p1, load_p2;
  logic [WIDTH-1:0]     scan_p0;

  // Stage 0 -> 1: handshake and count
  always_comb begin
    adv_p2  = !vld_p2_q || bus.I_Ready;
    adv_p1  = !vld_p1_q || adv_p2;
    acc_p0  = bus.I_Valid && adv_p1;
    load_p1 = acc_p0 && !bus.I_Flush;
    load_p2 = adv_p2 && vld_p1_q && !bus.I_Flush;

    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (bus.I_Flush) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end else begin
      if (adv_p2) vld_p2_d = vld_p1_q;
      if (adv_p1) vld_p1_d = acc_p0;
    end

    // Sign-bit mode: a 1 marks each place where adjacent bits differ; the
    // trailing 1 caps the count at WIDTH-1 for uniform operands.
    scan_p0 = bus.I_Mode ? {bus.I_Data[WIDTH-1:1] ^ bus.I_Data[WIDTH-2:0], 1'b1}
                         : bus.I_Data;

    data_p1_d = data_p1_q;
    num_p1_d  = num_p1_q;
    zero_p1_d = zero_p1_q;
    tag_p1_d  = tag_p1_q;
    if (load_p1) begin
      data_p1_d = bus.I_Data;
      num_p1_d  = lzc_tree(scan_p0);
      zero_p1_d = ~|bus.I_Data;
      tag_p1_d  = bus.I_Tag;
    end

    data_p2_d = data_p2_q;
    num_p2_d  = num_p2_q;
    zero_p2_d = zero_p2_q;
    tag_p2_d  = tag_p2_q;
    if (load_p2) begin
      data_p2_d = shl_log(data_p1_q, num_p1_q);
      num_p2_d  = num_p1_q;
      zero_p2_d = zero_p1_q;
      tag_p2_d  = tag_p1_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clock) begin
    data_p1_q <= data_p1_d;
    num_p1_q  <= num_p1_d;
    zero_p1_q <= zero_p1_d;
    tag_p1_q  <= tag_p1_d;
  end

  // Stage 1 -> 2: shifted result; cleared by reset so idle outputs read zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_p2_q <= '0;
      num_p2_q  <= '0;
      zero_p2_q <= 1'b0;
      tag_p2_q  <= '0;
    end else begin
      data_p2_q <= data_p2_d;
      num_p2_q  <= num_p2_d;
      zero_p2_q <= zero_p2_d;
      tag_p2_q  <= tag_p2_d;
    end
  end

  assign bus.O_Ready = adv_p1;
  assign bus.O_Valid = vld_p2_q;
  assign bus.O_Data  = data_p2_q;
  assign bus.O_Num   = num_p2_q;
  assign bus.O_Zero  = zero_p2_q;
  assign bus.O_Tag   = tag_p2_q;
endmodule

// File: tb/tb_nlz_norm_pipe.sv
// Directed bench for nlz_norm_pipe: vector table at WIDTH=32, stall/flush/reset
// sequences, and walking-one sweeps at WIDTH=8 and WIDTH=64.
module tb_nlz_norm_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nlz_norm_pipe_if #(.WIDTH(32), .TAG_WIDTH(8)) b32 ();
  nlz_norm_pipe_if #(.WIDTH(8),  .TAG_WIDTH(8)) b8 ();
  nlz_norm_pipe_if #(.WIDTH(64), .TAG_WIDTH(8)) b64 ();

  nlz_norm_pipe #(.WIDTH(32), .TAG_WIDTH(8)) dut32 (.clock(clk), .reset(rst_n), .bus(b32));
  nlz_norm_pipe #(.WIDTH(8),  .TAG_WIDTH(8)) dut8  (.clock(clk), .reset(rst_n), .bus(b8));
  nlz_norm_pipe #(.WIDTH(64), .TAG_WIDTH(8)) dut64 (.clock(clk), .reset(rst_n), .bus(b64));

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [5:0]  num;
    logic [31:0] odata;
    logic        zero;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_tag;
    logic [7:0]  push_tag;
    int          occ;
    logic        acc, out, saw_stall, hold_pend;
    logic [7:0]  h_tag;
    logic [5:0]  h_num;
    logic [31:0] h_data;

    vecs[0]  = '{1'b0, 32'h0000_0001, 8'h10, 6'd31, 32'h8000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0000, 8'h11, 6'd32, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_0000, 8'h12, 6'd31, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b1, 32'hFFFF_FF80, 8'h13, 6'd24, 32'h8000_0000, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 8'h14, 6'd24, 32'h4000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 8'h15, 6'd0,  32'h8000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 8'h16, 6'd31, 32'h8000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h7FFF_FFFF, 8'h17, 6'd0,  32'h7FFF_FFFF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0001_2345, 8'h18, 6'd15, 32'h91A2_8000, 1'b0};
    vecs[9]  = '{1'b1, 32'hC000_0000, 8'h19, 6'd1,  32'h8000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h00FF_0000, 8'h1A, 6'd8,  32'hFF00_0000, 1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_0000, 8'h1B, 6'd15, 32'h8000_0000, 1'b0};

    b32.I_Valid = 0; b32.I_Data = '0; b32.I_Mode = 0; b32.I_Tag = '0; b32.I_Flush = 0; b32.I_Ready = 1;
    b8.I_Valid  = 0; b8.I_Data  = '0; b8.I_Mode  = 0; b8.I_Tag  = '0; b8.I_Flush  = 0; b8.I_Ready  = 1;
    b64.I_Valid = 0; b64.I_Data = '0; b64.I_Mode = 0; b64.I_Tag = '0; b64.I_Flush = 0; b64.I_Ready = 1;

    // reset state
    #12;
    chk("rst_valid", 64'(b32.O_Valid), 64'd0);
    chk("rst_num",   64'(b32.O_Num),   64'd0);
    chk("rst_data",  64'(b32.O_Data),  64'd0);
    chk("rst_zero",  64'(b32.O_Zero),  64'd0);
    chk("rst_tag",   64'(b32.O_Tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_ready", 64'(b32.O_Ready), 64'd1);

    // table-driven vectors, one operand in flight at a time
    for (int i = 0; i < 12; i++) begin
      b32.I_Valid = 1; b32.I_Mode = vecs[i].mode; b32.I_Data = vecs[i].data; b32.I_Tag = vecs[i].tag;
      cyc();
      b32.I_Valid = 0;
      chk("vec_lat1_valid", 64'(b32.O_Valid), 64'd0);
      cyc();
      chk("vec_valid", 64'(b32.O_Valid), 64'd1);
      chk("vec_num",   64'(b32.O_Num),   64'(vecs[i].num));
      chk("vec_data",  64'(b32.O_Data),  64'(vecs[i].odata));
      chk("vec_zero",  64'(b32.O_Zero),  64'(vecs[i].zero));
      chk("vec_tag",   64'(b32.O_Tag),   64'(vecs[i].tag));
    end
    cyc();

    // stream tags 1..6 with downstream stalled on cycles 3..5
    exp_tag = 8'd1; push_tag = 8'd1; occ = 0; saw_stall = 0; hold_pend = 0;
    h_tag = '0; h_num = '0; h_data = '0;
    for (int c = 0; c < 40 && exp_tag != 8'd7; c++) begin
      b32.I_Valid = (push_tag <= 8'd6);
      b32.I_Mode  = 1'b0;
      b32.I_Data  = 32'h1 << push_tag;
      b32.I_Tag   = push_tag;
      b32.I_Ready = !(c >= 3 && c <= 5);
      #1;
      chk("stream_ready", 64'(b32.O_Ready), 64'((occ < 2) || b32.I_Ready));
      if (!b32.O_Ready) saw_stall = 1;
      if (hold_pend && b32.O_Valid) begin
        chk("hold_tag",  64'(b32.O_Tag),  64'(h_tag));
        chk("hold_num",  64'(b32.O_Num),  64'(h_num));
        chk("hold_data", 64'(b32.O_Data), 64'(h_data));
      end
      hold_pend = b32.O_Valid && !b32.I_Ready;
      h_tag = b32.O_Tag; h_num = b32.O_Num; h_data = b32.O_Data;
      acc = b32.I_Valid && b32.O_Ready;
      out = b32.O_Valid && b32.I_Ready;
      if (out) begin
        chk("stream_tag", 64'(b32.O_Tag), 64'(exp_tag));
        chk("stream_num", 64'(b32.O_Num), 64'(6'd31 - 6'(exp_tag)));
        exp_tag++;
      end
      @(posedge clk);
      if (acc) push_tag++;
      occ = occ + (acc ? 1 : 0) - (out ? 1 : 0);
      #1;
    end
    b32.I_Valid = 0; b32.I_Ready = 1;
    chk("stream_count", 64'(exp_tag), 64'd7);
    chk("stream_stalled", 64'(saw_stall), 64'd1);
    cyc(); cyc();

    // flush with a full, stalled pipeline
    b32.I_Ready = 0; b32.I_Mode = 0;
    b32.I_Valid = 1; b32.I_Data = 32'h10; b32.I_Tag = 8'hA1; cyc();
    b32.I_Tag = 8'hA2; cyc();
    chk("flush_full_valid", 64'(b32.O_Valid), 64'd1);
    chk("flush_full_ready", 64'(b32.O_Ready), 64'd0);
    b32.I_Flush = 1; b32.I_Tag = 8'hEE;
    cyc();
    b32.I_Flush = 0; b32.I_Valid = 0;
    chk("flush_valid0", 64'(b32.O_Valid), 64'd0);
    // flush that coincides with an accepted operand discards it
    b32.I_Ready = 1; b32.I_Valid = 1; b32.I_Flush = 1; b32.I_Tag = 8'hEF;
    #1;
    chk("flush_ready_reported", 64'(b32.O_Ready), 64'd1);
    cyc();
    b32.I_Flush = 0; b32.I_Data = 32'h100; b32.I_Tag = 8'hB0;
    chk("flush_after1", 64'(b32.O_Valid), 64'd0);
    cyc();
    b32.I_Valid = 0;
    chk("flush_dropped", 64'(b32.O_Valid), 64'd0);
    cyc();
    chk("flush_next_valid", 64'(b32.O_Valid), 64'd1);
    chk("flush_next_tag",   64'(b32.O_Tag),   64'hB0);
    chk("flush_next_num",   64'(b32.O_Num),   64'd23);
    cyc();

    // asynchronous reset mid-cycle with two operands in flight
    b32.I_Ready = 0;
    b32.I_Valid = 1; b32.I_Data = 32'h10; b32.I_Tag = 8'hC1; cyc();
    b32.I_Tag = 8'hC2; cyc();
    b32.I_Valid = 0;
    chk("arst_pre_valid", 64'(b32.O_Valid), 64'd1);
    chk("arst_pre_num",   64'(b32.O_Num),   64'd27);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(b32.O_Valid), 64'd0);
    chk("arst_num",   64'(b32.O_Num),   64'd0);
    chk("arst_data",  64'(b32.O_Data),  64'd0);
    chk("arst_tag",   64'(b32.O_Tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("arst_ready", 64'(b32.O_Ready), 64'd1);
    chk("arst_lost",  64'(b32.O_Valid), 64'd0);
    b32.I_Ready = 1;

    // walking-one sweep at WIDTH=8
    for (int i = 0; i < 8; i++) begin
      b8.I_Valid = 1; b8.I_Data = 8'(1 << i); b8.I_Tag = 8'(i);
      cyc();
      b8.I_Valid = 0;
      cyc();
      chk("w8_valid", 64'(b8.O_Valid), 64'd1);
      chk("w8_num",   64'(b8.O_Num),   64'(7 - i));
      chk("w8_data",  64'(b8.O_Data),  64'h80);
    end

    // walking-one sweep at WIDTH=64
    for (int i = 0; i < 64; i++) begin
      b64.I_Valid = 1; b64.I_Data = 64'h1 << i; b64.I_Tag = 8'(i);
      cyc();
      b64.I_Valid = 0;
      cyc();
      chk("w64_num",  64'(b64.O_Num),  64'(63 - i));
      chk("w64_data", 64'(b64.O_Data), 64'h8000_0000_0000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nlz_norm_pipe.md
# nlz_norm_pipe

Parametrised, pipelined leading-zero counter and normaliser for the scalar and vector datapaths. It generalises the fixed 32-bit combinational counter to any power-of-two width. It adds a redundant-sign-bit mode for signed operands and produces the left-normalised operand alongside the count. A two-stage valid/ready pipeline with backpressure lets it sit between the register-read stage and the FP/fixed-point normalisation logic without a combinational path through the count tree.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- TAG_WIDTH, 8: sideband tag carried unchanged with each operand.
- CW (localparam), $clog2(WIDTH)+1: count width; holds 0..WIDTH.

- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all valid bits and outputs.
- I_Valid  in  1  input operand valid.
- O_Ready  out  1  block accepts the operand this cycle.
- I_Data  in  WIDTH  operand.
- I_Mode  in  1  0: count leading zeros; 1: count redundant sign bits.
- I_Tag  in  TAG_WIDTH  sideband tag.
- I_Flush  in  1  synchronous flush; drops all in-flight operands.
- O_Valid  out  1  result valid.
- I_Ready  in  1  downstream accepts the result.
- O_Num  out  CW  count.
- O_Data  out  WIDTH  I_Data shifted left by O_Num, zero-filled; 0 for a zero operand.
- O_Zero  out  1  operand was all-zero.
- O_Tag  out  TAG_WIDTH  tag of the result.

## Operation
- Stage 1 (count):
  - Mode 0: O_Num = number of consecutive 0 bits from bit WIDTH-1 down; all-zero gives WIDTH.
  - Mode 1: count = number of consecutive bits equal to bit WIDTH-1, minus 1. Range is 0..WIDTH-1; all-zero and all-ones both give WIDTH-1.
  - Count tree: 8-bit leaf priority encoders, combined by a binary priority merge toward the MSB group.
  - Registers: operand, count, zero flag and tag.
- Stage 2 (shift): logarithmic left shifter by the registered count. A shift of WIDTH (mode 0, zero operand) yields 0. Registers: O_Data, O_Num, O_Zero and O_Tag.
- O_Zero = 1 only for an all-zero operand, in either mode.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - Stage 2 advances when it is empty or I_Ready=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - O_Ready = stage-1 empty OR stage 2 advances. No combinational path I_Valid→O_Valid; the I_Ready→O_Ready path is permitted.
- While O_Valid=1 and I_Ready=0, O_Data, O_Num, O_Zero and O_Tag are held stable.
- Results leave in acceptance order; no reordering and no drop except by flush or reset.
- I_Flush=1:
  - Both stage valid bits clear at the next edge.
  - An operand presented in the same cycle is discarded; O_Ready is still reported normally.
  - Flush has priority over advance.
- Reset:
  - Asynchronous assertion clears both valid bits immediately; O_Valid=0, O_Num=0, O_Data=0, O_Zero=0, O_Tag=0.
  - In-flight operands are lost.
  - O_Ready=1 on the first edge after deassertion.

## Timing
- Latency: 2 cycles. An operand accepted at edge n appears with O_Valid=1 after edge n+1, available for transfer at edge n+2.
- Throughput: one operand per cycle while I_Ready=1.
- Buffering: exactly 2 entries. With I_Ready held low, two operands are accepted, then O_Ready=0 until the output drains.
- Simultaneous input accept and output drain on a full pipeline: both occur; occupancy is unchanged.
- Critical path: count tree (stage 1) and shifter (stage 2) are isolated by the stage-1 register. Each stage needs ≤ log2(WIDTH)+2 mux levels.

## Test plan
- WIDTH=32, mode 0, I_Data=0x0000_0001, I_Ready=1 → two cycles later O_Num=31, O_Data=0x8000_0000, O_Zero=0.
- Mode 0 with I_Data=0x0000_0000 → O_Num=32, O_Data=0, O_Zero=1. Mode 1 with the same I_Data → O_Num=31, O_Zero=1.
- Mode 1, I_Data=0xFFFF_FF80 → O_Num=24, O_Data=0x8000_0000.
- Mode 1, I_Data=0x0000_0040 → O_Num=24, O_Data=0x4000_0000.
- Stream tags 1..6 back-to-back, with I_Ready low for cycles 3-5:
  - O_Ready drops after two operands are buffered.
  - Outputs stay stable while stalled.
  - Tags emerge 1..6 in order with no loss or duplication.
- Flush and reset:
  - Two operands in flight, I_Flush=1 for one cycle → O_Valid=0 next cycle; the next accepted operand emerges 2 cycles later.
  - Repeat with async reset asserted mid-cycle → outputs zero immediately; O_Ready=1 after release.
  - Sweep WIDTH=8 and 64 with a walking-one pattern; O_Num equals WIDTH-1-index.
